// File: rtl/phy_lane_rx_if.sv
// Serial lane bundle between the PHY serializer (master) and one lane receiver (slave).
interface phy_lane_rx_if;
    logic       transfer;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    modport master (output transfer, input data_out, input valid_out, input active);
    modport slave  (input transfer, output data_out, output valid_out, output active);
endinterface

// File: rtl/phy_lane_rx.sv
// One-lane serial-to-parallel receiver: COMMA-based byte alignment, lock after
// LOCK_COUNT aligned COMMAs, then one-cycle strobes for every non-filler byte.
module phy_lane_rx #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter logic [7:0] IDLE       = 8'h7C,
    parameter int         LOCK_COUNT = 4
) (
    input  logic          clk_8f,
    input  logic          reset,
    phy_lane_rx_if.slave  lane
);
    typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    state_t     state_reg, state_next;
    // Only the seven most recent bits are kept; the window appends the live bit.
    logic [6:0] sr_reg;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [3:0] bc_cnt_reg, bc_cnt_next;
    logic [7:0] data_reg, data_next;
    logic       valid_reg, valid_next;
    logic       active_reg, active_next;

    logic [7:0] w;
    logic       boundary;

    assign w        = {sr_reg, lane.transfer};
    assign boundary = (bit_cnt_reg == 3'd7);

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state_reg   <= SEARCH;
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
            bc_cnt_reg  <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            active_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sr_reg      <= w[6:0];
            bit_cnt_reg <= bit_cnt_next;
            bc_cnt_reg  <= bc_cnt_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            active_reg  <= active_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg + 3'd1;
        bc_cnt_next  = bc_cnt_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        active_next  = active_reg;
        unique case (state_reg)
            SEARCH: begin
                // Slide bit by bit; the counter is restarted on the COMMA that aligns us.
                bit_cnt_next = bit_cnt_reg;
                if (w == COMMA) begin
                    bit_cnt_next = 3'd0;
                    bc_cnt_next  = 4'd1;
                    state_next   = LOCKING;
                end
            end
            LOCKING: begin
                if (boundary) begin
                    if (w == COMMA) begin
                        bc_cnt_next = bc_cnt_reg + 4'd1;
                        if (bc_cnt_reg + 4'd1 == LOCK_TARGET) begin
                            state_next  = ACTIVE;
                            active_next = 1'b1;
                        end
                    end else begin
                        bc_cnt_next = 4'd0;
                        state_next  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (boundary && (w != COMMA) && (w != IDLE)) begin
                    data_next  = w;
                    valid_next = 1'b1;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    assign lane.data_out  = data_reg;
    assign lane.valid_out = valid_reg;
    assign lane.active    = active_reg;
endmodule

// File: tb/tb_phy_lane_rx.sv
// Directed + randomized bench for phy_lane_rx, checked every edge against a
// bit-position model of the alignment/lock/strobe rules.
module tb_phy_lane_rx;
    localparam logic [7:0] BC = 8'hBC;
    localparam logic [7:0] ID = 8'h7C;
    localparam int         LC = 4;

    logic clk_8f = 1'b0;
    logic reset  = 1'b1;

    phy_lane_rx_if lane ();

    phy_lane_rx #(.COMMA(BC), .IDLE(ID), .LOCK_COUNT(LC)) dut (
        .clk_8f (clk_8f),
        .reset  (reset),
        .lane   (lane.slave)
    );

    always #5 clk_8f = ~clk_8f;

    int checks   = 0;
    int failures = 0;

    bit         stream[$];
    bit         exp_v[$];
    bit         exp_a[$];
    logic [7:0] exp_d[$];
    int         strobe_n[$];
    int         first_valid;
    int         first_active;

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) stream.push_back(b[i]);
    endtask

    task automatic push_rand_bits(input int n);
        for (int i = 0; i < n; i++) stream.push_back(1'($urandom_range(0, 1)));
    endtask

    // Byte formed by the eight bits ending at stream index n (zeros before the start).
    function automatic logic [7:0] win(input int n);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = n - 7 + k;
            r = {r[6:0], (idx >= 0) ? stream[idx] : 1'b0};
        end
        return r;
    endfunction

    // Expected outputs after each edge: alignment anchored at the edge where a
    // COMMA was first seen, byte ends every 8 bits after that anchor.
    task automatic build_model();
        logic [7:0] cur_d;
        logic [7:0] wv;
        bit         locked;
        int         anchor;
        int         run;
        bit         v;
        cur_d = '0; locked = 0; anchor = -1; run = 0;
        exp_v.delete(); exp_a.delete(); exp_d.delete();
        for (int n = 0; n < stream.size(); n++) begin
            wv = win(n);
            v  = 0;
            if (locked) begin
                if (((n - anchor) % 8 == 0) && wv != BC && wv != ID) begin
                    cur_d = wv;
                    v     = 1;
                end
            end else if (anchor < 0) begin
                if (wv == BC) begin
                    anchor = n;
                    run    = 1;
                end
            end else if ((n - anchor) % 8 == 0) begin
                if (wv == BC) begin
                    run++;
                    if (run == LC) locked = 1;
                end else begin
                    anchor = -1;
                    run    = 0;
                end
            end
            exp_v.push_back(v);
            exp_a.push_back(locked);
            exp_d.push_back(cur_d);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_byte({tag, "_rst_data"},   lane.data_out,  8'h00);
        check_bit ({tag, "_rst_valid"},  lane.valid_out, 1'b0);
        check_bit ({tag, "_rst_active"}, lane.active,    1'b0);
    endtask

    // Reset, stream the queued bits, compare every edge, then assert reset
    // mid-cycle and confirm the outputs clear before any further edge.
    task automatic run_session(input string name);
        int fails_before;
        fails_before = failures;
        build_model();
        strobe_n.delete();
        first_valid  = -1;
        first_active = -1;
        lane.transfer = 1'b0;
        @(negedge clk_8f);
        reset = 1'b1;
        #1;
        check_reset_outputs(name);
        @(negedge clk_8f);
        reset = 1'b0;
        for (int n = 0; n < stream.size(); n++) begin
            lane.transfer = stream[n];
            @(posedge clk_8f);
            #1;
            check_bit ($sformatf("%s_valid_n%0d", name, n),  lane.valid_out, exp_v[n]);
            check_bit ($sformatf("%s_active_n%0d", name, n), lane.active,    exp_a[n]);
            check_byte($sformatf("%s_data_n%0d", name, n),   lane.data_out,  exp_d[n]);
            if (lane.valid_out === 1'b1) begin
                strobe_n.push_back(n);
                if (first_valid < 0) first_valid = n;
            end
            if (lane.active === 1'b1 && first_active < 0) first_active = n;
            @(negedge clk_8f);
        end
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs({name, "_async"});
        $display("session %-10s bits=%0d strobes=%0d first_valid=%0d first_active=%0d new_failures=%0d",
                 name, stream.size(), strobe_n.size(), first_valid, first_active, failures - fails_before);
        stream.delete();
    endtask

    initial begin
        // Lock: first BC ends at edge 7, active after edge 31, data after edge 39.
        repeat (4) push_byte(BC);
        push_byte(8'h55);
        push_byte(ID);
        run_session("lock");
        check_int("lock_active_edge", first_active, 31);
        check_int("lock_valid_edge",  first_valid,  39);
        check_int("lock_strobes",     strobe_n.size(), 1);

        // Filler filtering: only A3 and 01 strobe.
        repeat (4) push_byte(BC);
        push_byte(ID); push_byte(BC); push_byte(8'hA3); push_byte(ID); push_byte(8'h01);
        push_byte(ID);
        run_session("filler");
        check_int("filler_strobes", strobe_n.size(), 2);

        // Misaligned start.
        push_rand_bits(3);
        repeat (4) push_byte(BC);
        push_byte(8'h3C);
        push_byte(BC);
        run_session("misalign");
        check_int("misalign_strobes", strobe_n.size(), 1);

        // Broken lock sequence: 0x12 drops back to search, relock, only 0x99 delivered.
        push_byte(BC); push_byte(BC); push_byte(8'h12);
        repeat (4) push_byte(BC);
        push_byte(8'h99);
        push_byte(ID);
        run_session("broken");
        check_int("broken_strobes", strobe_n.size(), 1);

        // Locked, then the session ends three bits into a data byte (async reset while ACTIVE).
        repeat (4) push_byte(BC);
        push_byte(8'h5A);
        stream.push_back(1'b1); stream.push_back(1'b0); stream.push_back(1'b1);
        run_session("midreset");

        // After that reset: data without commas gives nothing until a fresh lock sequence.
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        repeat (4) push_byte(BC);
        push_byte(8'h77);
        run_session("relock");
        check_int("relock_strobes", strobe_n.size(), 1);

        // Back-to-back data 0x00..0x0F.
        repeat (4) push_byte(BC);
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        push_byte(ID);
        run_session("b2b");
        check_int("b2b_strobes", strobe_n.size(), 16);

        // Randomized sessions: random prefix, random byte mix including fillers.
        for (int s = 0; s < 4; s++) begin
            push_rand_bits(int'($urandom_range(0, 12)));
            repeat (int'($urandom_range(3, 5))) push_byte(BC);
            for (int i = 0; i < 12; i++) begin
                case ($urandom_range(0, 5))
                    0:       push_byte(BC);
                    1:       push_byte(ID);
                    default: push_byte(8'($urandom_range(0, 255)));
                endcase
            end
            run_session($sformatf("rand%0d", s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
